// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES pad emulator.
package snes_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int SNES_BITS_STD = 16;
  localparam int SNES_BITS_MIN = 12;
endpackage

// File: rtl/snes_sync_edge.sv
// Synchronises one async console pin and emits a registered level plus rise/fall pulses.
module snes_sync_edge
  import snes_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    level_d = sync_last;
    rise_d  = sync_last & ~level_q;
    fall_d  = ~sync_last & level_q;
  end

  // Reset to the pin's idle level so no phantom edge follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

// File: rtl/snes_pad_emulator.sv
// Multi-channel SNES pad emulator: console latch/clock drive per-channel serial shift registers.
module snes_pad_emulator
  import snes_pkg::*;
#(
  parameter int   CHANNELS    = 2,
  parameter int   WIDTH       = SNES_BITS_STD,
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL        = 1'b1,
  parameter int   INVERT      = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         snes_latch,
  input  logic                         snes_clk,
  input  logic [CHANNELS*WIDTH-1:0]    buttons,
  output logic [CHANNELS-1:0]          snes_data,
  output logic                         frame_done,
  output logic [$clog2(WIDTH+1)-1:0]   bit_index
);
  localparam int IW = $clog2(WIDTH+1);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl, clk_rise, clk_fall;

  snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch_sync (
    .clock(clock), .reset(reset), .async_in(snes_latch),
    .level(latch_lvl), .rise(latch_rise), .fall(latch_fall)
  );

  snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
    .clock(clock), .reset(reset), .async_in(snes_clk),
    .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
  );

  // Buttons are registered once so a change reaches the wire two cycles later while in LOAD.
  logic [CHANNELS-1:0][WIDTH-1:0] buttons_q, buttons_d;

  always_comb buttons_d = (INVERT != 0) ? ~buttons : buttons;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) buttons_q <= '0;
    else       buttons_q <= buttons_d;
  end

  state_t        state_q;
  logic [IW-1:0] bit_index_q;
  logic          frame_done_q;
  logic          load_en, shift_en;

  // Latch level dominates any same-cycle clock rise.
  assign load_en  = latch_lvl;
  assign shift_en = clk_rise & ~latch_lvl & ((state_q == SHIFT) || (state_q == DONE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_index_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (latch_lvl) begin
        state_q     <= LOAD;
        bit_index_q <= '0;
      end else begin
        case (state_q)
          LOAD: state_q <= SHIFT;
          SHIFT: begin
            if (clk_rise) begin
              bit_index_q <= bit_index_q + 1'b1;
              if (bit_index_q == IW'(WIDTH-1)) begin
                state_q      <= DONE;
                frame_done_q <= 1'b1;
              end
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
      sr_d = sr_q;
      if (load_en)       sr_d = buttons_q[c];
      else if (shift_en) sr_d = {FILL, sr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) sr_q <= '1;
      else       sr_q <= sr_d;
    end

    assign snes_data[c] = sr_q[0];
  end

  assign frame_done = frame_done_q;
  assign bit_index  = bit_index_q;

  logic unused_ok;
  assign unused_ok = latch_rise ^ latch_fall ^ clk_lvl ^ clk_fall;
endmodule

// File: tb/tb_snes_pad_emulator.sv
// Directed bench for snes_pad_emulator: 16-bit inverted 2-channel pad and 12-bit plain pad.
module tb_snes_pad_emulator;
  logic        clock = 1'b0;
  logic        reset;
  logic        snes_latch;
  logic        snes_clk;
  logic [31:0] buttons;
  logic [1:0]  snes_data;
  logic        frame_done;
  logic [4:0]  bit_index;
  logic [11:0] buttons12;
  logic [0:0]  data12;
  logic        fd12;
  logic [3:0]  idx12;

  int vectors = 0;
  int errors  = 0;
  int fd_count = 0;
  int fd12_count = 0;
  logic [4:0] fd_idx = '0;

  logic [15:0] exp0 = 16'b0111_1111_1111_1110;
  logic [15:0] exp1 = 16'b1111_1111_1111_1110;
  logic [11:0] exp12 = 12'b1010_0101_1010;

  always #5 clock = ~clock;

  snes_pad_emulator #(.CHANNELS(2), .WIDTH(16), .SYNC_STAGES(2), .FILL(1'b1), .INVERT(1)) dut (
    .clock(clock), .reset(reset), .snes_latch(snes_latch), .snes_clk(snes_clk),
    .buttons(buttons), .snes_data(snes_data), .frame_done(frame_done), .bit_index(bit_index)
  );

  snes_pad_emulator #(.CHANNELS(1), .WIDTH(12), .SYNC_STAGES(2), .FILL(1'b1), .INVERT(0)) dut12 (
    .clock(clock), .reset(reset), .snes_latch(snes_latch), .snes_clk(snes_clk),
    .buttons(buttons12), .snes_data(data12), .frame_done(fd12), .bit_index(idx12)
  );

  always @(negedge clock) begin
    if (frame_done) begin
      fd_count = fd_count + 1;
      fd_idx   = bit_index;
    end
    if (fd12) fd12_count = fd12_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic console_pulse();
    snes_clk = 1'b0;
    repeat (8) @(negedge clock);
    snes_clk = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic latch_pulse();
    snes_latch = 1'b1;
    repeat (8) @(negedge clock);
    snes_latch = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; snes_latch = 1'b0; snes_clk = 1'b1;
    buttons = 32'h0001_8001; buttons12 = 12'hA5A;
    repeat (3) @(negedge clock);
    vectors++; if (snes_data !== 2'b11) begin errors++; $display("FAIL reset_data: got %b want 11", snes_data); end
    vectors++; if (bit_index !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bit_index); end
    vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    reset = 1'b0;
    repeat (6) @(negedge clock);
    vectors++; if (snes_data !== 2'b11) begin errors++; $display("FAIL idle_data: got %b want 11", snes_data); end
  endtask

  task automatic test_full_frame();
    latch_pulse();
    vectors++; if (snes_data !== 2'b00) begin errors++; $display("FAIL frame_bit0: got %b want 00", snes_data); end
    vectors++; if (bit_index !== 5'd0) begin errors++; $display("FAIL frame_idx0: got %0d want 0", bit_index); end
    for (int k = 1; k < 16; k++) begin
      console_pulse();
      vectors++;
      if (snes_data !== {exp1[k], exp0[k]}) begin
        errors++; $display("FAIL frame_bit%0d: got %b want %b", k, snes_data, {exp1[k], exp0[k]});
      end
      vectors++;
      if (bit_index !== 5'(k)) begin errors++; $display("FAIL frame_idx%0d: got %0d want %0d", k, bit_index, k); end
    end
    vectors++; if (fd_count !== 0) begin errors++; $display("FAIL frame_early_fd: got %0d want 0", fd_count); end
    for (int k = 16; k < 19; k++) begin
      console_pulse();
      vectors++; if (snes_data !== 2'b11) begin errors++; $display("FAIL frame_fill%0d: got %b want 11", k, snes_data); end
      vectors++; if (bit_index !== 5'd16) begin errors++; $display("FAIL frame_sat%0d: got %0d want 16", k, bit_index); end
    end
    vectors++; if (fd_count !== 1) begin errors++; $display("FAIL frame_fd_count: got %0d want 1", fd_count); end
    vectors++; if (fd_idx !== 5'd16) begin errors++; $display("FAIL frame_fd_idx: got %0d want 16", fd_idx); end
  endtask

  task automatic test_abort();
    int base;
    base = fd_count;
    latch_pulse();
    repeat (5) console_pulse();
    vectors++; if (bit_index !== 5'd5) begin errors++; $display("FAIL abort_idx5: got %0d want 5", bit_index); end
    snes_latch = 1'b1;
    repeat (8) @(negedge clock);
    vectors++; if (bit_index !== 5'd0) begin errors++; $display("FAIL abort_idx0: got %0d want 0", bit_index); end
    vectors++; if (snes_data !== 2'b00) begin errors++; $display("FAIL abort_bit0: got %b want 00", snes_data); end
    snes_latch = 1'b0;
    repeat (8) @(negedge clock);
    console_pulse();
    vectors++; if (snes_data !== 2'b11) begin errors++; $display("FAIL abort_bit1: got %b want 11", snes_data); end
    vectors++; if (bit_index !== 5'd1) begin errors++; $display("FAIL abort_idx1: got %0d want 1", bit_index); end
    vectors++; if (fd_count !== base) begin errors++; $display("FAIL abort_fd: got %0d want %0d", fd_count, base); end
  endtask

  task automatic test_simultaneous();
    snes_clk = 1'b0;
    repeat (8) @(negedge clock);
    snes_latch = 1'b1; snes_clk = 1'b1;
    repeat (8) @(negedge clock);
    vectors++; if (bit_index !== 5'd0) begin errors++; $display("FAIL simul_idx: got %0d want 0", bit_index); end
    vectors++; if (snes_data !== 2'b00) begin errors++; $display("FAIL simul_data: got %b want 00", snes_data); end
    snes_latch = 1'b0;
    repeat (8) @(negedge clock);
    vectors++; if (bit_index !== 5'd0) begin errors++; $display("FAIL simul_after: got %0d want 0", bit_index); end
    console_pulse();
    vectors++; if (bit_index !== 5'd1) begin errors++; $display("FAIL simul_next: got %0d want 1", bit_index); end
  endtask

  task automatic test_reset_mid();
    int base;
    latch_pulse();
    repeat (7) console_pulse();
    vectors++; if (bit_index !== 5'd7) begin errors++; $display("FAIL rmid_idx7: got %0d want 7", bit_index); end
    reset = 1'b1;
    #1;
    vectors++; if (snes_data !== 2'b11) begin errors++; $display("FAIL rmid_data: got %b want 11", snes_data); end
    vectors++; if (bit_index !== 5'd0) begin errors++; $display("FAIL rmid_idx: got %0d want 0", bit_index); end
    vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rmid_fd: got %b want 0", frame_done); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    base = fd_count;
    latch_pulse();
    vectors++; if (snes_data !== 2'b00) begin errors++; $display("FAIL rmid_bit0: got %b want 00", snes_data); end
    for (int k = 1; k < 16; k++) begin
      console_pulse();
      vectors++;
      if (snes_data !== {exp1[k], exp0[k]}) begin
        errors++; $display("FAIL rmid_bit%0d: got %b want %b", k, snes_data, {exp1[k], exp0[k]});
      end
    end
    console_pulse();
    vectors++; if (fd_count !== base + 1) begin errors++; $display("FAIL rmid_fd_count: got %0d want %0d", fd_count, base + 1); end
  endtask

  task automatic test_width12();
    int base;
    base = fd12_count;
    latch_pulse();
    vectors++; if (data12[0] !== exp12[0]) begin errors++; $display("FAIL w12_bit0: got %b want %b", data12[0], exp12[0]); end
    for (int k = 1; k < 12; k++) begin
      console_pulse();
      vectors++;
      if (data12[0] !== exp12[k]) begin errors++; $display("FAIL w12_bit%0d: got %b want %b", k, data12[0], exp12[k]); end
    end
    for (int k = 12; k < 14; k++) begin
      console_pulse();
      vectors++; if (data12[0] !== 1'b1) begin errors++; $display("FAIL w12_fill%0d: got %b want 1", k, data12[0]); end
      vectors++; if (idx12 !== 4'd12) begin errors++; $display("FAIL w12_idx%0d: got %0d want 12", k, idx12); end
    end
    vectors++; if (fd12_count !== base + 1) begin errors++; $display("FAIL w12_fd: got %0d want %0d", fd12_count, base + 1); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    test_width12();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
